// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC fixed/float conversion path.
// Pure declarations, no latency; no flow control of its own.
// Holds the float field widths and bias, the Q2.30 format, and the packer state enum.
package cordic_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_MANT_W = 23;
    localparam int FP_EXP_W  = 8;

    // Q2.30: two integer bits (including sign), thirty fractional bits.
    localparam int Q_INT_BITS  = 2;
    localparam int Q_FRAC_BITS = 30;
    localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        ROUND,
        HOLD
    } pack_state_t;

endpackage

// File: rtl/fp_round_pack.sv
// Packs sign, normalised magnitude and shift count into a single-precision float with RNE.
// Latency: purely combinational.
// Backpressure: none; the enclosing FSM holds the inputs stable.
module fp_round_pack
    import cordic_pkg::*;
#(
    parameter int WIDTH     = Q_WIDTH,
    parameter int FRAC_BITS = Q_FRAC_BITS,
    parameter int LZ_W      = $clog2(WIDTH)
) (
    input  logic             sign,
    input  logic [WIDTH-1:0] mag,
    input  logic [LZ_W-1:0]  lz,
    output logic [31:0]      fp
);

    // Exponent of a magnitude whose MSB is already set (lz == 0).
    localparam logic [FP_EXP_W-1:0] EXP_OFF = FP_EXP_W'(FP_BIAS + WIDTH - 1 - FRAC_BITS);

    logic [FP_MANT_W-1:0] mant;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic [FP_MANT_W:0]   mant_rnd;
    logic [FP_EXP_W-1:0]  exp_base;
    logic [FP_EXP_W-1:0]  exp_fin;

    always_comb begin
        // mag[WIDTH-1] is the implicit leading one and is not stored.
        mant     = mag[WIDTH-2 -: FP_MANT_W];
        guard    = mag[WIDTH-2-FP_MANT_W];
        sticky   = |mag[WIDTH-3-FP_MANT_W:0];
        round_up = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {{FP_MANT_W{1'b0}}, round_up};
        exp_base = EXP_OFF - FP_EXP_W'(lz);
        // Carry out of the mantissa leaves it all zeros and bumps the exponent.
        exp_fin  = exp_base + {{(FP_EXP_W-1){1'b0}}, mant_rnd[FP_MANT_W]};
        if (mag == '0) begin
            fp = 32'h0000_0000;
        end else begin
            fp = {sign, exp_fin, mant_rnd[FP_MANT_W-1:0]};
        end
    end

endmodule

// File: rtl/fixed_to_float_packer.sv
// Converts a signed Q2.30 word into an IEEE-754 single, normalising one bit per cycle.
// Latency: lz+2 cycles from input handshake to out_valid (2 for zero); one word in flight.
// Backpressure: in_ready only in IDLE; result held stable in HOLD until out_ready.
module fixed_to_float_packer
    import cordic_pkg::*;
#(
    parameter int FRAC_BITS = Q_FRAC_BITS,
    parameter int WIDTH     = Q_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data
);

    localparam int LZ_W = $clog2(WIDTH);

    pack_state_t      state;
    pack_state_t      state_nxt;
    logic             sign_q;
    logic [WIDTH-1:0] mag_q;
    logic [LZ_W-1:0]  lz_q;
    logic [WIDTH-1:0] mag_in;
    logic [31:0]      pack_fp;

    // Negating the most negative value wraps back to itself, which is the correct unsigned magnitude.
    assign mag_in   = in_data[WIDTH-1] ? -in_data : in_data;
    assign in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = ((mag_in == '0) || mag_in[WIDTH-1]) ? ROUND : NORM;
                end
            end
            NORM: begin
                // The bit shifted into the MSB this cycle ends normalisation.
                if (mag_q[WIDTH-2]) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: state_nxt = HOLD;
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            lz_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= 32'h0000_0000;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= in_data[WIDTH-1];
                        mag_q  <= mag_in;
                        lz_q   <= '0;
                    end
                end
                NORM: begin
                    mag_q <= mag_q << 1;
                    lz_q  <= lz_q + LZ_W'(1);
                end
                ROUND: begin
                    out_data  <= pack_fp;
                    out_valid <= 1'b1;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    fp_round_pack #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .LZ_W      (LZ_W)
    ) u_round_pack (
        .sign (sign_q),
        .mag  (mag_q),
        .lz   (lz_q),
        .fp   (pack_fp)
    );

`ifndef SYNTHESIS
    // Q2.30 inputs keep the unrounded exponent well inside the normal range.
    always_ff @(posedge clk) begin
        if (!rst && state == ROUND && mag_q != '0) begin
            assert ((FP_BIAS + WIDTH - 1 - FRAC_BITS - int'(lz_q)) >= 97 &&
                    (FP_BIAS + WIDTH - 1 - FRAC_BITS - int'(lz_q)) <= 129);
        end
    end
`endif

endmodule

// File: tb/tb_fixed_to_float_packer.sv
// Bench for fixed_to_float_packer: directed corner words plus randomized words with random backpressure,
// compared against an arithmetic Q2.30-to-float reference.
module tb_fixed_to_float_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fixed_to_float_packer #(
        .FRAC_BITS (30),
        .WIDTH     (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Position of the highest set bit of the magnitude of x (x nonzero).
    function automatic int top_bit(input logic [31:0] x);
        longint m;
        int     p;
        m = x[31] ? -longint'($signed(x)) : longint'(x);
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        return p;
    endfunction

    // Value is m * 2^-30; float value = q * 2^(e-127-23) with q rounded to 24 bits, ties to even.
    function automatic logic [31:0] ref_float(input logic [31:0] x);
        longint m, q, r, half;
        int     p, e;
        logic   s;
        if (x == 32'h0) return 32'h0;
        s = x[31];
        m = s ? -longint'($signed(x)) : longint'(x);
        p = top_bit(x);
        e = p - 30 + 127;
        if (p > 23) begin
            q    = m >> (p - 23);
            r    = m - (q << (p - 23));
            half = longint'(1) << (p - 24);
            if (r > half || (r == half && q[0])) q++;
            if (q == (longint'(1) << 24)) begin
                q = q >> 1;
                e++;
            end
        end else begin
            q = m << (23 - p);
        end
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic int ref_latency(input logic [31:0] x);
        if (x == 32'h0) return 2;
        return (31 - top_bit(x)) + 2;
    endfunction

    // Accept one word, wait for the result, apply `hold` cycles of backpressure, then complete the output handshake.
    task automatic convert(input logic [31:0] x, input int hold);
        int          k;
        logic [31:0] first;
        @(negedge clk);
        check("in_ready_idle", {31'b0, in_ready}, 32'd1);
        in_data  = x;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        k = 1;
        while (!out_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("latency_%h", x), k, ref_latency(x));
        check($sformatf("data_%h", x), out_data, ref_float(x));
        first = out_data;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
            check("hold_data", out_data, first);
            check("hold_busy", {30'b0, out_valid, in_ready}, 32'd2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after_hs", {30'b0, out_valid, in_ready}, 32'd1);
    endtask

    logic [31:0] directed [8] = '{32'h4000_0000, 32'hC000_0000, 32'h26DD_3B6A, 32'h0000_0000,
                                  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};

    initial begin
        int spurious;
        logic [31:0] w;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0);
        rst = 1'b0;

        // Test-plan vectors cross-checked against hand-derived constants as well as the model.
        check("ref_one", ref_float(32'h4000_0000), 32'h3F80_0000);
        check("ref_gain", ref_float(32'h26DD_3B6A), 32'h3F1B_74EE);
        check("ref_carry", ref_float(32'h7FFF_FFFF), 32'h4000_0000);
        check("ref_m2", ref_float(32'h8000_0000), 32'hC000_0000);

        foreach (directed[i]) convert(directed[i], 0);
        convert(32'h26DD_3B6A, 5);
        convert(32'h4000_0000, 0);

        // Reset in the middle of a long normalisation.
        @(negedge clk);
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_norm_busy", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {30'b0, out_valid, in_ready}, 32'd1);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("abort_no_output", spurious, 0);
        convert(32'h0000_0003, 1);

        for (int n = 0; n < 250; n++) begin
            w = $urandom;
            case ($urandom_range(0, 3))
                0: w = w >> $urandom_range(0, 31);
                1: w = $signed(w) >>> $urandom_range(0, 31);
                2: w = (w >> $urandom_range(0, 31)) ^ {32{w[0]}};
                default: ;
            endcase
            convert(w, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
